// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED scroll controller: FSM state encoding,
// LED register geometry and the one-bit pattern rotation.
package led_ctrl_pkg;

  localparam int   LED_W      = 24;
  localparam logic LED_ADR_LO = 1'b0;
  localparam logic LED_ADR_HI = 1'b1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_LO,
    GAP_LO,
    WR_HI,
    GAP_HI
  } state_e;

  // dir_right = 0: bit23 wraps into bit0; dir_right = 1: bit0 wraps into bit23.
  function automatic logic [LED_W-1:0] rotate(input logic [LED_W-1:0] pat,
                                              input logic             dir_right);
    return dir_right ? {pat[0], pat[LED_W-1:1]} : {pat[LED_W-2:0], pat[LED_W-1]};
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Scroll-tick prescaler: counts 0..TICK_DIV-1 and flags the terminal count
// for exactly one cycle before wrapping.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    tick_o = (cnt_q == CNT_MAX);
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_scroll_ctrl.sv
// LED scroll sequencer: holds a 24-bit pattern, rotates it on prescaled ticks or
// loads it from the host, and replays it to the LED port as two strobed writes.
module led_scroll_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned       TICK_DIV = 50_000_000,
  parameter logic [LED_W-1:0]  RST_PAT  = 24'h000001
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             run_i,
  input  logic             dir_i,
  input  logic             host_req_i,
  input  logic [LED_W-1:0] host_pat_i,
  output logic             host_ack_o,
  output logic             busy_o,
  output logic [LED_W-1:0] pattern_o,
  output logic [15:0]      led_dat_o,
  output logic             led_adr_o,
  output logic             led_cs_n_o,
  output logic             led_iow_n_o
);

  state_e           state_q, state_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic             tick_pend_q, tick_pend_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             iow_n_q, iow_n_d;
  logic             adr_q, adr_d;
  logic [15:0]      dat_q, dat_d;
  logic             tick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    tick_pend_d = tick_pend_q;
    ack_d       = 1'b0;
    adr_d       = adr_q;
    dat_d       = dat_q;

    unique case (state_q)
      INIT:   state_d = WR_LO;
      IDLE: begin
        // Host load beats a pending tick; the tick stays pending for the next IDLE.
        if (host_req_i) begin
          state_d   = WR_LO;
          pattern_d = host_pat_i;
          ack_d     = 1'b1;
        end else if (tick_pend_q && run_i) begin
          state_d     = WR_LO;
          pattern_d   = rotate(pattern_q, dir_i);
          tick_pend_d = 1'b0;
        end
      end
      WR_LO:  state_d = GAP_LO;
      GAP_LO: state_d = WR_HI;
      WR_HI:  state_d = GAP_HI;
      GAP_HI: state_d = IDLE;
      default: state_d = INIT;
    endcase

    if (tick) tick_pend_d = 1'b1;

    // Outputs are decoded from the next state so the registered port matches the state it belongs to.
    cs_n_d  = !((state_d == WR_LO) || (state_d == WR_HI));
    iow_n_d = cs_n_d;
    busy_d  = (state_d != IDLE);
    if (state_d == WR_LO) begin
      adr_d = LED_ADR_LO;
      dat_d = pattern_d[15:0];
    end else if (state_d == WR_HI) begin
      adr_d = LED_ADR_HI;
      dat_d = {8'h00, pattern_d[LED_W-1:16]};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= INIT;
      pattern_q   <= RST_PAT;
      tick_pend_q <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      iow_n_q     <= 1'b1;
      adr_q       <= LED_ADR_LO;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      tick_pend_q <= tick_pend_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      iow_n_q     <= iow_n_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  assign host_ack_o  = ack_q;
  assign busy_o      = busy_q;
  assign pattern_o   = pattern_q;
  assign led_dat_o   = dat_q;
  assign led_adr_o   = adr_q;
  assign led_cs_n_o  = cs_n_q;
  assign led_iow_n_o = iow_n_q;

endmodule
